// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and common word types.
// Imported by the writeback stage and the EX forwarding logic.
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;
  localparam int REG_ZERO  = 0;
  localparam int LINK_REG  = 31;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    word_t;

endpackage

// File: rtl/wb_select.sv
// Writeback selection: data, destination and write strobe from MEM/WB.
// Shared with EX forwarding so the destination rules live in one place.
module wb_select #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int LINK_REG = cpu_pkg::LINK_REG
) (
  input  logic              enable,
  input  logic              iRegWrite,
  input  logic              iMemToReg,
  input  logic              iJumps,
  input  logic [DATA_W-1:0] iReadData,
  input  logic [DATA_W-1:0] iResult,
  input  cpu_pkg::reg_idx_t iRegDest,
  output logic [DATA_W-1:0] wbData,
  output cpu_pkg::reg_idx_t wbDest,
  output logic              wbWrite
);

  import cpu_pkg::*;

  localparam reg_idx_t LinkIdx = reg_idx_t'(LINK_REG);
  localparam reg_idx_t ZeroIdx = reg_idx_t'(REG_ZERO);

  // Jump-and-link wins over the load select.
  always_comb begin
    wbDest = iJumps ? LinkIdx : iRegDest;
    wbData = iResult;
    if (!iJumps && iMemToReg)
      wbData = iReadData;
    wbWrite = enable
            & (iRegWrite | iJumps)
            & (wbDest != ZeroIdx);
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file with write-first
// bypass on both read ports, plus a retired-instruction counter.
module wb_regfile #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NREGS    = 32,
  parameter int LINK_REG = cpu_pkg::LINK_REG,
  parameter int CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              iRegWrite,
  input  logic              iMemToReg,
  input  logic              iJumps,
  input  logic [DATA_W-1:0] iIR,
  input  logic [DATA_W-1:0] iReadData,
  input  logic [DATA_W-1:0] iResult,
  input  cpu_pkg::reg_idx_t iRegDest,
  input  cpu_pkg::reg_idx_t rsAddr,
  input  cpu_pkg::reg_idx_t rtAddr,
  output logic [DATA_W-1:0] rsData,
  output logic [DATA_W-1:0] rtData,
  output logic [DATA_W-1:0] wbData,
  output cpu_pkg::reg_idx_t wbDest,
  output logic              wbWrite,
  output logic [CNT_W-1:0]  retired
);

  import cpu_pkg::*;

  localparam reg_idx_t ZeroIdx = reg_idx_t'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic              selEn;

  // Reset blocks the strobe so a pending write cannot land.
  assign selEn = enable & ~reset;

  wb_select #(
    .DATA_W  (DATA_W),
    .LINK_REG(LINK_REG)
  ) u_sel (
    .enable   (selEn),
    .iRegWrite(iRegWrite),
    .iMemToReg(iMemToReg),
    .iJumps   (iJumps),
    .iReadData(iReadData),
    .iResult  (iResult),
    .iRegDest (iRegDest),
    .wbData   (wbData),
    .wbDest   (wbDest),
    .wbWrite  (wbWrite)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wbWrite) begin
      regs[wbDest] <= wbData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      retired <= '0;
    else if (enable && iIR != '0)
      retired <= retired + CNT_W'(1);
  end

  always_comb begin
    rsData = '0;
    if (!reset && rsAddr != ZeroIdx) begin
      if (wbWrite && rsAddr == wbDest)
        rsData = wbData;
      else
        rsData = regs[rsAddr];
    end
  end

  always_comb begin
    rtData = '0;
    if (!reset && rtAddr != ZeroIdx) begin
      if (wbWrite && rtAddr == wbDest)
        rtData = wbData;
      else
        rtData = regs[rtAddr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: scoreboard of expected values,
// compared with immediate assertions as outputs are sampled.
module tb_wb_regfile;

  import cpu_pkg::*;

  logic     clock = 1'b0;
  logic     reset = 1'b0;
  logic     enable = 1'b0;
  logic     iRegWrite = 1'b0;
  logic     iMemToReg = 1'b0;
  logic     iJumps = 1'b0;
  word_t    iIR = '0;
  word_t    iReadData = '0;
  word_t    iResult = '0;
  reg_idx_t iRegDest = '0;
  reg_idx_t rsAddr = '0;
  reg_idx_t rtAddr = '0;

  word_t       rsData, rtData, wbData;
  reg_idx_t    wbDest;
  logic        wbWrite;
  logic [31:0] retired;

  word_t       rsData4, rtData4, wbData4;
  reg_idx_t    wbDest4;
  logic        wbWrite4;
  logic [3:0]  retired4;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sbq[$];
  int          expRet = 0;
  logic [31:0] seq [8] = '{32'h20080001, 32'h0, 32'hAC080000, 32'h0,
                           32'h8C090000, 32'h0, 32'h08000004, 32'h01095020};

  always #50 clock = ~clock;

  wb_regfile dut (
    .clock(clock), .reset(reset), .enable(enable),
    .iRegWrite(iRegWrite), .iMemToReg(iMemToReg), .iJumps(iJumps),
    .iIR(iIR), .iReadData(iReadData), .iResult(iResult),
    .iRegDest(iRegDest), .rsAddr(rsAddr), .rtAddr(rtAddr),
    .rsData(rsData), .rtData(rtData), .wbData(wbData),
    .wbDest(wbDest), .wbWrite(wbWrite), .retired(retired)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable),
    .iRegWrite(iRegWrite), .iMemToReg(iMemToReg), .iJumps(iJumps),
    .iIR(iIR), .iReadData(iReadData), .iResult(iResult),
    .iRegDest(iRegDest), .rsAddr(rsAddr), .rtAddr(rtAddr),
    .rsData(rsData4), .rtData(rtData4), .wbData(wbData4),
    .wbDest(wbDest4), .wbWrite(wbWrite4), .retired(retired4)
  );

  task automatic push(input logic [31:0] v);
    sbq.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL %s observed=%h expected=<none>", tag, obs);
      return;
    end
    e = sbq.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic bubble;
    iIR = '0;
    iRegWrite = 1'b0;
    iJumps = 1'b0;
    iMemToReg = 1'b0;
  endtask

  initial begin
    // power-on reset, with a write request held during reset
    #1 reset = 1'b1;
    enable = 1'b1;
    iRegWrite = 1'b1;
    iRegDest = 5'd4;
    iResult = 32'h11;
    #1;
    push(0); chk("rst_retired", retired);
    push(0); chk("rst_wbWrite", {31'b0, wbWrite});
    iRegWrite = 1'b0;
    tick;
    reset = 1'b0;

    // ALU writeback with same-cycle bypass
    iRegWrite = 1'b1; iMemToReg = 1'b0; iRegDest = 5'd5;
    iResult = 32'h1234; iIR = 32'h20050000; rsAddr = 5'd5;
    #1;
    push(32'h1234); chk("bypass_rs5", rsData);
    push(1);        chk("bypass_wbWrite", {31'b0, wbWrite});
    tick; expRet++;
    bubble;
    #1;
    push(32'h1234); chk("stored_rs5", rsData);
    push(expRet);   chk("retired_t1", retired);

    // load writeback
    iMemToReg = 1'b1; iRegWrite = 1'b1; iReadData = 32'hDEADBEEF;
    iResult = 32'h1; iRegDest = 5'd9; iIR = 32'h8C090000;
    #1;
    push(32'hDEADBEEF); chk("load_wbData", wbData);
    tick; expRet++;
    bubble; rtAddr = 5'd9;
    #1;
    push(32'hDEADBEEF); chk("stored_rt9", rtData);

    // write to register 0 is suppressed
    iRegWrite = 1'b1; iRegDest = 5'd0; iResult = 32'hFFFF;
    iIR = 32'h20000000; rsAddr = 5'd0;
    #1;
    push(0); chk("r0_wbWrite", {31'b0, wbWrite});
    push(0); chk("r0_bypass", rsData);
    tick; expRet++;
    bubble;
    #1;
    push(0); chk("r0_stored", rsData);

    // jump-and-link forces r31, ignores iMemToReg
    iJumps = 1'b1; iRegDest = 5'd7; iResult = 32'h400C;
    iMemToReg = 1'b1; iReadData = 32'hBADBAD; iIR = 32'h0C000000;
    #1;
    push(31);         chk("jal_wbDest", {27'b0, wbDest});
    push(32'h400C);   chk("jal_wbData", wbData);
    tick; expRet++;
    bubble; rsAddr = 5'd31; rtAddr = 5'd7;
    #1;
    push(32'h400C); chk("jal_r31", rsData);
    push(0);        chk("jal_r7", rtData);

    // retirement: four counted, one non-bubble stalled on the 3rd
    for (int i = 0; i < 8; i++) begin
      iIR = seq[i];
      enable = (i != 2);
      tick;
    end
    expRet += 4;
    enable = 1'b1;
    bubble;
    #1;
    push(expRet); chk("retired_seq", retired);

    // stall: no commit, no bypass, no count
    iRegWrite = 1'b1; iRegDest = 5'd3; iResult = 32'hAAAA;
    iIR = 32'h20030000;
    tick; expRet++;
    enable = 1'b0; iResult = 32'h55; iIR = 32'h20030001; rtAddr = 5'd3;
    #1;
    push(32'hAAAA); chk("stall_nobypass", rtData);
    push(0);        chk("stall_wbWrite", {31'b0, wbWrite});
    tick;
    enable = 1'b1;
    bubble;
    #1;
    push(32'hAAAA); chk("stall_r3", rtData);
    push(expRet);   chk("stall_retired", retired);

    // identical read addresses share the bypass
    rsAddr = 5'd5; rtAddr = 5'd5;
    iRegWrite = 1'b1; iRegDest = 5'd5; iResult = 32'h77;
    iIR = 32'h20050077;
    #1;
    push(32'h77); chk("same_rs", rsData);
    push(32'h77); chk("same_rt", rtData);
    tick; expRet++;

    // asynchronous reset between edges with a pending write
    iRegWrite = 1'b1; iRegDest = 5'd10; iResult = 32'h99;
    iIR = 32'h200A0099;
    #20;
    reset = 1'b1;
    #1;
    push(0); chk("arst_retired", retired);
    push(0); chk("arst_retired4", {28'b0, retired4});
    push(0); chk("arst_wbWrite", {31'b0, wbWrite});
    for (int a = 1; a < 32; a++) begin
      rsAddr = reg_idx_t'(a);
      rtAddr = reg_idx_t'(a);
      #1;
      push(0); chk($sformatf("arst_rs%0d", a), rsData);
      push(0); chk($sformatf("arst_rt%0d", a), rtData);
    end
    tick;
    bubble;
    reset = 1'b0;
    rsAddr = 5'd10;
    rtAddr = 5'd5;
    #1;
    push(0); chk("arst_r10_dropped", rsData);
    push(0); chk("arst_r5_cleared", rtData);
    expRet = 0;

    // 16 retirements wrap the 4-bit counter
    iIR = 32'h00000020;
    for (int i = 0; i < 16; i++) begin
      tick;
      expRet++;
    end
    bubble;
    #1;
    push(expRet % 16); chk("wrap_retired4", {28'b0, retired4});
    push(expRet);      chk("wrap_retired32", retired);

    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
